// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for the L1 line-fill/writeback interface. Requests
//   are captured into an in-order queue (the initiator has no back-pressure).
//   A small FSM drains the queue. Writes commit one per cycle. A read waits
//   READ_LATENCY cycles and then returns its line with a one-cycle strobe.
//
//   Optional build macro: MEM_STATS_EN enables the rd_count/wr_count
//   statistics counters. When it is undefined, both ports read constant 0.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mem_req_valid              single-cycle request strobe
//   mem_req_rw                 1 = write (writeback), 0 = read (fill)
//   mem_req_addr[14:0]         line address; low log2(MEM_LINES) bits used
//   mem_req_wdata[255:0]       write line data
//   mem_resp_valid             single-cycle read response strobe
//   mem_resp_rdata[255:0]      read data; holds its value between responses
//   busy                       queue non-empty or FSM not idle
//   req_overflow               sticky: a request was dropped on a full queue
//   rd_count, wr_count[15:0]   completed reads / committed writes
module line_mem_responder #(
  parameter int unsigned MEM_LINES    = 1024,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned QDEPTH       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req_valid,
  input  logic         mem_req_rw,
  input  logic [14:0]  mem_req_addr,
  input  logic [255:0] mem_req_wdata,
  output logic         mem_resp_valid,
  output logic [255:0] mem_resp_rdata,
  output logic         busy,
  output logic         req_overflow,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam int unsigned QA_W  = $clog2(QDEPTH);
  localparam int unsigned PTR_W = QA_W + 1;
  localparam logic [7:0]  CNT_INIT = 8'(READ_LATENCY - 1);

  typedef logic [255:0] line_t;
  typedef line_t mem_t [MEM_LINES];
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Power-up image: line i, word k = {i[15:0], k[15:0]}. Not touched by reset.
  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned i = 0; i < MEM_LINES; i++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        m[i][32*k +: 32] = {i[15:0], k[15:0]};
      end
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  // Upper address bits alias onto the stored lines and are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^(mem_req_addr >> IDX_W);

  // ---------------- request queue ----------------
  logic              q_rw    [QDEPTH];
  logic [IDX_W-1:0]  q_idx   [QDEPTH];
  line_t             q_wdata [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [QA_W-1:0]   head;
  logic              empty, full, push, pop;

  assign head  = rd_ptr[QA_W-1:0];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[QA_W] != rd_ptr[QA_W]) &&
                 (wr_ptr[QA_W-1:0] == rd_ptr[QA_W-1:0]);
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push  = mem_req_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      req_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (mem_req_valid && !push) req_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rw[wr_ptr[QA_W-1:0]]    <= mem_req_rw;
      q_idx[wr_ptr[QA_W-1:0]]   <= mem_req_addr[IDX_W-1:0];
      q_wdata[wr_ptr[QA_W-1:0]] <= mem_req_wdata;
    end
  end

  // ---------------- FSM ----------------
  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              mem_we, load_rd, dec_cnt, resp_fire;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    mem_we    = 1'b0;
    load_rd   = 1'b0;
    dec_cnt   = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (q_rw[head]) begin
            mem_we = 1'b1;
          end else begin
            load_rd = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          dec_cnt = 1'b1;
        end else begin
          resp_fire = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rd_idx_q       <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
    end else begin
      state_q        <= state_d;
      mem_resp_valid <= resp_fire;
      if (load_rd) begin
        cnt_q    <= CNT_INIT;
        rd_idx_q <= q_idx[head];
      end else if (dec_cnt) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (resp_fire) mem_resp_rdata <= mem_q[rd_idx_q];
    end
  end

  // Writes only commit in IDLE, so they never collide with the WAIT-state read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[q_idx[head]] <= q_wdata[head];
  end

  assign busy = !empty || (state_q != S_IDLE);

  // ---------------- statistics ----------------
`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (resp_fire) rd_count <= rd_count + 16'd1;
      if (mem_we)    wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_rw = 1'b0;
  logic [14:0]  mem_req_addr = '0;
  logic [255:0] mem_req_wdata = '0;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_rdata;
  logic         busy;
  logic         req_overflow;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  line_mem_responder #(
    .MEM_LINES(1024),
    .READ_LATENCY(4),
    .QDEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .busy(busy),
    .req_overflow(req_overflow),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response log sampled on the falling edge.
  logic [255:0] resp_q [$];
  int unsigned  resp_cyc [$];
  always @(negedge clk) begin
    if (mem_resp_valid) begin
      resp_q.push_back(mem_resp_rdata);
      resp_cyc.push_back(cyc);
    end
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input int unsigned i);
    logic [255:0] l;
    for (int unsigned k = 0; k < 8; k++) l[32*k +: 32] = {i[15:0], k[15:0]};
    return l;
  endfunction

  function automatic logic [15:0] exp_cnt(input int unsigned n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [14:0] addr, input logic [255:0] data,
                      output int unsigned edge_cyc);
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_wdata = data;
    tick();
    edge_cyc      = cyc;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, busy, 1'b0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    resp_q.delete();
    resp_cyc.delete();
  endtask

  logic [255:0] dead = {8{32'hDEADBEEF}};
  logic [255:0] d40  = {8{32'h40A5C3F0}};
  logic [255:0] d77  = {8{32'h77123456}};
  // Back-to-back burst of 8 reads to lines 0x100..0x107 with 4 queue entries:
  // requests 5 and 7 arrive while full with no pop and are dropped.
  int unsigned burst_lines [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h106};

  initial begin
    int unsigned e;
    int unsigned n;

    // Reset state
    repeat (3) tick();
    check("rst_resp_valid", mem_resp_valid, 1'b0);
    check("rst_resp_rdata", mem_resp_rdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", req_overflow, 1'b0);
    check("rst_rd_count", rd_count, 16'd0);
    check("rst_wr_count", wr_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Plain read: latency and init pattern
    send(1'b0, 15'h0005, '0, e);
    wait_idle("t1_idle");
    check("t1_nresp", resp_q.size(), 1);
    if (resp_q.size() > 0) begin
      check("t1_data", resp_q[0], init_line(5));
      check("t1_latency", resp_cyc[0], e + 5);
    end
    check("t1_hold", mem_resp_rdata, init_line(5));
    check("t1_valid_low", mem_resp_valid, 1'b0);

    // Write then read of the same line
    do_reset();
    send(1'b1, 15'h0012, dead, e);
    send(1'b0, 15'h0012, '0, e);
    wait_idle("t2_idle");
    check("t2_nresp", resp_q.size(), 1);
    if (resp_q.size() > 0) check("t2_data", resp_q[0], dead);
    check("t2_wr_count", wr_count, exp_cnt(1));
    check("t2_rd_count", rd_count, exp_cnt(1));

    // Writeback of 0x40 followed by fill of 0x41, then read 0x40
    resp_q.delete();
    resp_cyc.delete();
    send(1'b1, 15'h0040, d40, e);
    send(1'b0, 15'h0041, '0, e);
    wait_idle("t3_idle_a");
    send(1'b0, 15'h0040, '0, e);
    wait_idle("t3_idle_b");
    check("t3_nresp", resp_q.size(), 2);
    if (resp_q.size() > 1) begin
      check("t3_fill41", resp_q[0], init_line(32'h41));
      check("t3_read40", resp_q[1], d40);
    end

    // Overflow burst
    resp_q.delete();
    resp_cyc.delete();
    check("t4_ovf_before", req_overflow, 1'b0);
    for (int unsigned i = 0; i < 8; i++) send(1'b0, 15'(32'h100 + i), '0, e);
    check("t4_overflow", req_overflow, 1'b1);
    wait_idle("t4_idle");
    check("t4_nresp", resp_q.size(), 6);
    n = (resp_q.size() < 6) ? resp_q.size() : 6;
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("t4_data%0d", i), resp_q[i], init_line(burst_lines[i]));

    // Address aliasing: 0x405 maps to line 5
    resp_q.delete();
    resp_cyc.delete();
    send(1'b0, 15'h0405, '0, e);
    wait_idle("t5_idle");
    check("t5_nresp", resp_q.size(), 1);
    if (resp_q.size() > 0) check("t5_alias", resp_q[0], init_line(5));

    // Reset pulsed while a read is waiting
    resp_q.delete();
    resp_cyc.delete();
    send(1'b1, 15'h0077, d77, e);
    send(1'b0, 15'h0077, '0, e);
    repeat (3) tick();
    check("t6_busy_wait", busy, 1'b1);
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t6_no_resp", resp_q.size(), 0);
    check("t6_overflow_clr", req_overflow, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_rd_count", rd_count, 16'd0);
    check("t6_wr_count", wr_count, 16'd0);
    send(1'b0, 15'h0077, '0, e);
    wait_idle("t6_idle");
    check("t6_nresp", resp_q.size(), 1);
    if (resp_q.size() > 0) check("t6_retained", resp_q[0], d77);
    check("t6_rd_after", rd_count, exp_cnt(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the L1 line-fill/writeback interface. Accepts 256-bit line requests from the cache controller and returns read data after a programmable latency.
- Used as the backing-store model in cache benches and as the front end of the on-chip line SRAM.
- Requests are buffered in an in-order queue, because the initiator has no back-pressure input and may issue a writeback and a fill on consecutive cycles.

Parameters:
- MEM_LINES, 1024, number of 256-bit lines stored; power of 2; index = mem_req_addr[log2(MEM_LINES)-1:0], upper bits ignored (aliasing).
- READ_LATENCY, 4, WAIT-state cycles per read; legal range 1..255.
- QDEPTH, 4, request queue entries; power of 2, >=2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_req_valid  in  1  single-cycle request strobe; no ready
- mem_req_rw  in  1  1=write (writeback), 0=read (fill)
- mem_req_addr  in  15  line (block) address
- mem_req_wdata  in  256  write line data
- mem_resp_valid  out  1  single-cycle read response strobe
- mem_resp_rdata  out  256  read line data, valid with mem_resp_valid
- busy  out  1  queue non-empty or FSM not IDLE
- req_overflow  out  1  sticky: a request was dropped because the queue was full
- rd_count  out  16  reads completed (MEM_STATS_EN only)
- wr_count  out  16  writes committed (MEM_STATS_EN only)

Behaviour:
- Reset values: mem_resp_valid=0, mem_resp_rdata=0, busy=0, req_overflow=0, rd_count=0, wr_count=0. Queue emptied, FSM forced to IDLE.
- Line storage is not cleared by reset. Initial content: line i, 32-bit word k (bits 32k+31:32k) = {i[15:0], k[15:0]}.
- Enqueue: each edge with mem_req_valid=1 captures {rw, addr, wdata} into the queue tail.
  - If the queue is full and no pop occurs that edge, drop the request and set req_overflow.
  - Push and pop on the same edge while full: accepted, no overflow.
- FSM states:
  - IDLE, queue empty: no action.
  - IDLE, head is a write: commit wdata to line, pop, remain IDLE. Throughput is one write per cycle.
  - IDLE, head is a read: pop, latch index, cnt<=READ_LATENCY-1, go to WAIT.
  - WAIT, cnt!=0: cnt<=cnt-1.
  - WAIT, cnt==0: mem_resp_valid<=1, mem_resp_rdata<=line[latched index] read that cycle, go to IDLE.
- mem_resp_valid is high for exactly one cycle per read. mem_resp_rdata holds its last value afterwards.
- Latency: a read enqueued at edge N on an empty/IDLE responder gives mem_resp_valid high in the cycle after edge N+1+READ_LATENCY.
- Ordering: strictly in order. A write queued ahead of a read is committed before the read samples storage, so read-after-write returns the new data. This covers the same-line case and a writeback to line A followed by a fill of line B.
- Reads are not pipelined: one read outstanding in WAIT at a time; later requests wait in the queue.
- Writes produce no response.
- Reset asserted mid-WAIT: the response is discarded (never issued), the queue is cleared, storage is retained.
- Queue pointers are log2(QDEPTH)+1 bits wide and wrap modulo 2*QDEPTH.
- full = MSBs differ and low bits equal; empty = pointers equal.

Optional Feature:
- MEM_STATS_EN defined:
  - rd_count increments on each mem_resp_valid.
  - wr_count increments on each write commit.
  - Both are 16-bit, wrap 0xFFFF->0, and are cleared by reset.
- MEM_STATS_EN undefined: counter logic is not present; rd_count and wr_count are driven constant 0. Ports remain.

Test Plan:
- After reset, READ_LATENCY=4, read addr 0x0005 at edge N -> single-cycle mem_resp_valid after edge N+5; rdata word k = {16'h0005, 16'hk} for k=0..7.
- Write addr 0x0012 with data {8{32'hDEADBEEF}}, read 0x0012 on the next cycle -> response equals {8{32'hDEADBEEF}}, no response for the write, wr_count=1, rd_count=1.
- Write 0x0040 (data D), read 0x0041 on the next edge (cache writeback+fill pattern) -> response = init pattern of line 0x41; a later read of 0x40 returns D.
- QDEPTH=4: 8 consecutive reads on back-to-back edges -> req_overflow=1, exactly the non-dropped reads respond, in order, with correct per-line data; busy drops to 0 after the last response.
- Address 0x0405 with MEM_LINES=1024 -> aliases to line 5; rdata = line 5 contents.
- Reset pulsed while in WAIT -> no mem_resp_valid; req_overflow and counters cleared; a subsequent read of a previously written line returns the written data.
